// File: rtl/bp_pkg.sv
// Shared constants and types for the path history unit.
// Imported by the checkpoint FIFO and the top level.
package bp_pkg;
  localparam int HIST_W = 12;
  localparam int DEPTH  = 8;
  localparam int PTR_W  = $clog2(DEPTH);

  typedef logic [HIST_W-1:0] hist_t;

  typedef struct packed {
    hist_t hist;
    logic  pred;
  } ckpt_t;
endpackage

// File: rtl/checkpoint_fifo.sv
// Circular checkpoint store for in-flight branches.
// Flush empties the FIFO and wins over a same-cycle push.
module checkpoint_fifo
  import bp_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  ckpt_t            wdata,
  output ckpt_t            head_data,
  output logic [PTR_W-1:0] tail,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  ckpt_t            mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] head_nxt;
  logic             wr;

  assign wr        = push && !flush;
  assign head_nxt  = head + PTR_W'(pop);
  assign head_data = mem[head];
  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);

  always_ff @(posedge clock) begin
    if (wr) mem[tail] <= wdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head <= head_nxt;
      if (flush) begin
        // Restart the queue right after the popped entry.
        tail  <= head_nxt;
        count <= '0;
      end else begin
        tail  <= tail + PTR_W'(wr);
        count <= count + (PTR_W+1)'(wr)
                       - (PTR_W+1)'(pop);
      end
    end
  end

endmodule

// File: rtl/path_history_unit.sv
// Speculative and architectural path history with
// per-branch checkpoints and mispredict recovery.
module path_history_unit
  import bp_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             pred_valid,
  input  logic             pred_taken,
  output logic             pred_ready,
  output logic [PTR_W-1:0] pred_tag,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  output hist_t            PHresult,
  output hist_t            commit_history,
  output logic             mispredict,
  output logic [PTR_W:0]   occupancy,
  output logic             resolve_error
);

  ckpt_t head_data;
  ckpt_t wdata;
  logic  full;
  logic  empty;
  logic  do_push;
  logic  do_res;
  logic  wrong;
  logic  push_eff;

  assign pred_ready = !full;
  assign do_push    = pred_valid && !full;
  assign do_res     = resolve_valid && !empty;
  assign wrong      = do_res
                   && (resolve_taken != head_data.pred);
  // A wrong resolve refetches, so its companion push is dropped.
  assign push_eff   = do_push && !wrong;
  assign wdata      = '{hist: PHresult, pred: pred_taken};

  checkpoint_fifo u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push_eff),
    .pop       (do_res),
    .flush     (wrong),
    .wdata     (wdata),
    .head_data (head_data),
    .tail      (pred_tag),
    .full      (full),
    .empty     (empty),
    .count     (occupancy)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      PHresult       <= '0;
      commit_history <= '0;
      mispredict     <= 1'b0;
      resolve_error  <= 1'b0;
    end else begin
      mispredict <= wrong;
      if (resolve_valid && empty) resolve_error <= 1'b1;
      if (do_res)
        commit_history <= {commit_history[HIST_W-2:0],
                           resolve_taken};
      if (wrong)
        PHresult <= {head_data.hist[HIST_W-2:0],
                     resolve_taken};
      else if (push_eff)
        PHresult <= {PHresult[HIST_W-2:0], pred_taken};
    end
  end

endmodule

// File: tb/tb_path_history_unit.sv
// Directed plus randomized bench for path_history_unit
// against a queue-based reference model.
module tb_path_history_unit;
  import bp_pkg::*;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             pred_valid = 1'b0;
  logic             pred_taken = 1'b0;
  logic             pred_ready;
  logic [PTR_W-1:0] pred_tag;
  logic             resolve_valid = 1'b0;
  logic             resolve_taken = 1'b0;
  hist_t            PHresult;
  hist_t            commit_history;
  logic             mispredict;
  logic [PTR_W:0]   occupancy;
  logic             resolve_error;

  path_history_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .pred_ready     (pred_ready),
    .pred_tag       (pred_tag),
    .resolve_valid  (resolve_valid),
    .resolve_taken  (resolve_taken),
    .PHresult       (PHresult),
    .commit_history (commit_history),
    .mispredict     (mispredict),
    .occupancy      (occupancy),
    .resolve_error  (resolve_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    int hist;
    bit pred;
  } m_ent_t;

  m_ent_t m_q[$];
  int     m_ph;
  int     m_commit;
  int     m_head;
  int     m_tail;
  bit     m_mis;
  bit     m_err;
  int     checks = 0;
  int     errors = 0;
  localparam int MASK = (1 << HIST_W) - 1;

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_ph = 0;
    m_commit = 0;
    m_head = 0;
    m_tail = 0;
    m_mis = 0;
    m_err = 0;
  endtask

  task automatic check_outs(string tag);
    chk({tag, ".ph"}, int'(PHresult), m_ph);
    chk({tag, ".commit"}, int'(commit_history), m_commit);
    chk({tag, ".occ"}, int'(occupancy), m_q.size());
    chk({tag, ".mis"}, int'(mispredict), int'(m_mis));
    chk({tag, ".err"}, int'(resolve_error), int'(m_err));
    chk({tag, ".rdy"}, int'(pred_ready),
        int'(m_q.size() != DEPTH));
    chk({tag, ".tag"}, int'(pred_tag), m_tail);
    if (occupancy != 0)
      chk({tag, ".inv"}, int'(dut.u_fifo.head_data.hist),
          int'(commit_history));
  endtask

  // One clock cycle: drive, advance model, sample after edge.
  task automatic step(string tag, bit pv, bit pt,
                      bit rv, bit rt);
    bit full, push, res, wrong;
    m_ent_t e;
    pred_valid = pv;
    pred_taken = pt;
    resolve_valid = rv;
    resolve_taken = rt;
    full = (m_q.size() == DEPTH);
    push = pv && !full;
    res = rv && (m_q.size() != 0);
    wrong = 0;
    if (rv && m_q.size() == 0) m_err = 1;
    if (res) begin
      e = m_q.pop_front();
      m_commit = ((m_commit << 1) | int'(rt)) & MASK;
      m_head = (m_head + 1) % DEPTH;
      if (rt != e.pred) begin
        wrong = 1;
        m_ph = ((e.hist << 1) | int'(rt)) & MASK;
        m_q.delete();
        m_tail = m_head;
      end
    end
    if (push && !wrong) begin
      m_q.push_back('{hist: m_ph, pred: pt});
      m_ph = ((m_ph << 1) | int'(pt)) & MASK;
      m_tail = (m_tail + 1) % DEPTH;
    end
    m_mis = wrong;
    @(posedge clock);
    #1;
    pred_valid = 0;
    resolve_valid = 0;
    check_outs(tag);
  endtask

  function automatic bit head_pred();
    return (m_q.size() != 0) ? m_q[0].pred : 1'b0;
  endfunction

  initial begin
    m_reset();
    #12;
    check_outs("rst_hold");
    @(negedge clock);
    reset_n = 1;
    @(posedge clock);
    #1;
    check_outs("rst");
    chk("rst.ph0", int'(PHresult), 0);

    step("p0", 1, 1, 0, 0);
    step("p1", 1, 1, 0, 0);
    step("p2", 1, 0, 0, 0);
    chk("t2.ph", int'(PHresult), 'h006);
    chk("t2.occ", int'(occupancy), 3);

    step("r0", 0, 0, 1, 1);
    step("r1", 0, 0, 1, 1);
    step("r2", 0, 0, 1, 0);
    chk("t3.commit", int'(commit_history), 'h006);

    for (int i = 0; i < 4; i++) step("p4", 1, 1, 0, 0);
    chk("t4.ph", int'(PHresult), 'h06F);
    step("r4", 0, 0, 1, 0);
    chk("t4.mis", int'(mispredict), 1);
    chk("t4.ph2", int'(PHresult), 'h00C);
    chk("t4.commit", int'(commit_history), 'h00C);
    step("r4idle", 0, 0, 0, 0);
    chk("t4.pulse", int'(mispredict), 0);

    for (int i = 0; i < 8; i++)
      step("p5", 1, ($urandom & 1) == 1, 0, 0);
    chk("t5.rdy", int'(pred_ready), 0);
    step("p5full", 1, 1, 0, 0);
    step("r5", 0, 0, 1, head_pred());
    chk("t5.occ", int'(occupancy), 7);
    step("pr5", 1, 0, 1, head_pred());
    chk("t5.occ2", int'(occupancy), 7);
    for (int i = 0; i < 7; i++)
      step("r5d", 0, 0, 1, head_pred());

    step("r6e", 0, 0, 1, 1);
    chk("t6.err", int'(resolve_error), 1);
    for (int i = 0; i < 3; i++) step("p6", 1, 1, 0, 0);
    #2;
    reset_n = 0;
    m_reset();
    #1;
    check_outs("t6.async");
    @(negedge clock);
    reset_n = 1;
    @(posedge clock);
    #1;
    check_outs("t6.rel");

    for (int i = 0; i < 400; i++) begin
      bit rv, rt;
      rv = ($urandom_range(0, 2) == 0);
      rt = ($urandom_range(0, 4) == 0) ? !head_pred()
                                        : head_pred();
      step("rnd", $urandom_range(0, 3) != 0,
           ($urandom & 1) == 1, rv, rt);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=done");
    $fatal(1, "timeout");
  end

endmodule
